// File: rtl/aes256_key_expand.sv
// Iterative AES-256 key schedule: emits round keys rk0..rk14 on a valid/ready stream, one per transfer.
// Optional round-key store with read port is enabled by defining AES256_KE_STORE_EN.
module aes256_key_expand #(
  parameter bit ZERO_ON_IDLE = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] key,
  input  logic         key_load,
  input  logic         rk_ready,
  output logic         rk_valid,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_idx,
  output logic         rk_last,
  output logic         busy,
  output logic         done
`ifdef AES256_KE_STORE_EN
  ,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_data,
  output logic         store_valid
`endif
);

  // FIPS-197 S-box, byte 0x00 in the top byte of the table.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state, state_d;
  logic [255:0]   window, window_d;
  logic [3:0]     idx, idx_d;
  logic           busy_d, done_d;
  logic           transfer;
  logic [31:0]    w7, t_word, n0, n1, n2, n3;
  logic [7:0]     rcon;

  // Stream handshake: rk_valid is high for the whole RUN state; a round key
  // moves on a cycle where rk_valid & rk_ready are both high, and rk_data /
  // rk_idx hold steady until then. key_load overrides any transfer.
  assign rk_valid = (state == RUN);
  assign transfer = rk_valid & rk_ready;
  assign rk_idx   = idx;
  assign rk_last  = rk_valid & (idx == 4'd14);
  assign rk_data  = (ZERO_ON_IDLE && !rk_valid) ? '0 : window[255:128];

  // Next 4 schedule words; even steps use RotWord + Rcon, odd steps plain SubWord.
  assign w7     = window[31:0];
  assign rcon   = 8'h01 << idx[3:1];
  assign t_word = idx[0] ? sub_word(w7)
                         : (sub_word({w7[23:0], w7[31:24]}) ^ {rcon, 24'h0});
  assign n0 = window[255:224] ^ t_word;
  assign n1 = window[223:192] ^ n0;
  assign n2 = window[191:160] ^ n1;
  assign n3 = window[159:128] ^ n2;

  always_comb begin
    state_d  = state;
    window_d = window;
    idx_d    = idx;
    busy_d   = busy;
    done_d   = 1'b0;
    if (key_load) begin
      state_d  = RUN;
      window_d = key;
      idx_d    = 4'd0;
      busy_d   = 1'b1;
    end else if (transfer) begin
      if (idx == 4'd14) begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        idx_d    = idx + 4'd1;
        window_d = {window[127:0], n0, n1, n2, n3};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      window <= '0;
      idx    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_d;
      window <= window_d;
      idx    <= idx_d;
      busy   <= busy_d;
      done   <= done_d;
    end
  end

`ifdef AES256_KE_STORE_EN
  logic [127:0] bank [15];

  // Only transfers that are not overridden by key_load are stored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 15; i++) bank[i] <= '0;
    end else if (transfer && !key_load) begin
      bank[idx] <= window[255:128];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      store_valid <= 1'b0;
    end else if (key_load) begin
      store_valid <= 1'b0;
    end else if (done) begin
      store_valid <= 1'b1;
    end
  end

  assign rd_data = (rd_idx <= 4'd14) ? bank[rd_idx] : '0;
`endif

endmodule

// File: tb/tb_aes256_key_expand.sv
// Bench for aes256_key_expand: FIPS-197 A.3 vector table, scoreboard-checked stream,
// backpressure, abort/restart, async reset, and the AES256_KE_STORE_EN read port when defined.
module tb_aes256_key_expand;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] key;
  logic         key_load;
  logic         rk_ready;
  logic         rk_valid;
  logic [127:0] rk_data;
  logic [3:0]   rk_idx;
  logic         rk_last;
  logic         busy;
  logic         done;
`ifdef AES256_KE_STORE_EN
  logic [3:0]   rd_idx;
  logic [127:0] rd_data;
  logic         store_valid;
`endif

  always #5 clk = ~clk;

  aes256_key_expand dut (
    .clk(clk), .rst(rst), .key(key), .key_load(key_load), .rk_ready(rk_ready),
    .rk_valid(rk_valid), .rk_data(rk_data), .rk_idx(rk_idx), .rk_last(rk_last),
    .busy(busy), .done(done)
`ifdef AES256_KE_STORE_EN
    , .rd_idx(rd_idx), .rd_data(rd_data), .store_valid(store_valid)
`endif
  );

  localparam logic [255:0] KEY_A3 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] rk;
    logic         last;
  } vec_t;

  vec_t         vec [15];
  logic [132:0] exp_q [$];
  logic [132:0] e;
  int           tests = 0;
  int           fails = 0;
  int           done_cnt = 0;
  bit           sb_on = 1'b0;
  logic         stall_prev = 1'b0;
  logic [127:0] data_prev;
  logic [3:0]   idx_prev;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load_key(input logic [255:0] k);
    @(posedge clk); #1;
    key      = k;
    key_load = 1'b1;
    @(posedge clk); #1;
    key_load = 1'b0;
  endtask

  task automatic push_vecs(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({vec[i].idx, vec[i].rk, vec[i].last});
  endtask

  // Scoreboard / stream monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (stall_prev && rst) begin
      check("hold_valid", {127'd0, rk_valid}, 128'd1);
      check("hold_data", rk_data, data_prev);
      check("hold_idx", {124'd0, rk_idx}, {124'd0, idx_prev});
    end
    if (sb_on && rk_valid && rk_ready && !key_load) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_extra: unexpected key idx %0d data %h", rk_idx, rk_data);
      end else begin
        e = exp_q.pop_front();
        check("sb_rk", rk_data, e[128:1]);
        check("sb_idx", {124'd0, rk_idx}, {124'd0, e[132:129]});
        check("sb_last", {127'd0, rk_last}, {127'd0, e[0]});
      end
    end
    stall_prev = rst && rk_valid && !rk_ready && !key_load;
    data_prev  = rk_data;
    idx_prev   = rk_idx;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int dcnt;
    bit seen;

    vec[0]  = '{4'd0,  128'h603deb1015ca71be2b73aef0857d7781, 1'b0};
    vec[1]  = '{4'd1,  128'h1f352c073b6108d72d9810a30914dff4, 1'b0};
    vec[2]  = '{4'd2,  128'h9ba354118e6925afa51a8b5f2067fcde, 1'b0};
    vec[3]  = '{4'd3,  128'ha8b09c1a93d194cdbe49846eb75d5b9a, 1'b0};
    vec[4]  = '{4'd4,  128'hd59aecb85bf3c917fee94248de8ebe96, 1'b0};
    vec[5]  = '{4'd5,  128'hb5a9328a2678a647983122292f6c79b3, 1'b0};
    vec[6]  = '{4'd6,  128'h812c81addadf48ba24360af2fab8b464, 1'b0};
    vec[7]  = '{4'd7,  128'h98c5bfc9bebd198e268c3ba709e04214, 1'b0};
    vec[8]  = '{4'd8,  128'h68007bacb2df331696e939e46c518d80, 1'b0};
    vec[9]  = '{4'd9,  128'hc814e20476a9fb8a5025c02d59c58239, 1'b0};
    vec[10] = '{4'd10, 128'hde1369676ccc5a71fa2563959674ee15, 1'b0};
    vec[11] = '{4'd11, 128'h5886ca5d2e2f31d77e0af1fa27cf73c3, 1'b0};
    vec[12] = '{4'd12, 128'h749c47ab18501ddae2757e4f7401905a, 1'b0};
    vec[13] = '{4'd13, 128'hcafaaae3e4d59b349adf6acebd10190d, 1'b0};
    vec[14] = '{4'd14, 128'hfe4890d1e6188d0b046df344706c631e, 1'b1};

    rst      = 1'b0;
    key      = '0;
    key_load = 1'b0;
    rk_ready = 1'b0;
`ifdef AES256_KE_STORE_EN
    rd_idx   = 4'd0;
`endif

    // Reset, then idle with no key_load.
    #1;
    check("rst_data", rk_data, 128'd0);
    check("rst_ctrl", {120'd0, rk_valid, busy, done, rk_last, rk_idx}, 128'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c == 5) rk_ready = 1'b1;
      @(posedge clk); #1;
      check("idle_data", rk_data, 128'd0);
      check("idle_ctrl", {120'd0, rk_valid, busy, done, rk_last, rk_idx}, 128'd0);
    end

    // FIPS-197 A.3 key, rk_ready held high: one key per cycle.
    rk_ready = 1'b1;
    push_vecs(15);
    sb_on = 1'b1;
    load_key(KEY_A3);
    check("a3_busy", {127'd0, busy}, 128'd1);
    for (int i = 0; i < 15; i++) begin
      check("a3_valid", {127'd0, rk_valid}, 128'd1);
      check("a3_idx", {124'd0, rk_idx}, {124'd0, vec[i].idx});
      check("a3_rk", rk_data, vec[i].rk);
      check("a3_last", {127'd0, rk_last}, {127'd0, vec[i].last});
      @(posedge clk); #1;
    end
    check("a3_done", {126'd0, done, busy}, 128'd2);
    check("a3_valid_off", {127'd0, rk_valid}, 128'd0);
    check("a3_idle_data", rk_data, 128'd0);
    @(posedge clk); #1;
    check("a3_done_pulse", {127'd0, done}, 128'd0);
    check("a3_q_empty", 128'(exp_q.size()), 128'd0);
    sb_on = 1'b0;

`ifdef AES256_KE_STORE_EN
    check("st_valid", {127'd0, store_valid}, 128'd1);
    rd_idx = 4'd3;  #1 check("st_rd3", rd_data, vec[3].rk);
    rd_idx = 4'd14; #1 check("st_rd14", rd_data, vec[14].rk);
    rd_idx = 4'd15; #1 check("st_rd15", rd_data, 128'd0);
    repeat (3) @(posedge clk);
    #1 check("st_valid_hold", {127'd0, store_valid}, 128'd1);
`endif

    // Backpressure: pseudo-random rk_ready, same 15 keys in order.
    push_vecs(15);
    sb_on = 1'b1;
    load_key(KEY_A3);
`ifdef AES256_KE_STORE_EN
    check("st_clear", {127'd0, store_valid}, 128'd0);
`endif
    seen = 1'b0;
    for (int c = 0; c < 600; c++) begin
      rk_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("bp_done_seen", {127'd0, seen}, 128'd1);
    check("bp_q_empty", 128'(exp_q.size()), 128'd0);
    sb_on = 1'b0;
    rk_ready = 1'b1;
    repeat (2) @(posedge clk);

    // Abort at rk_idx=5 with an all-zero key.
    exp_q.delete();
    push_vecs(5);
    sb_on = 1'b1;
    dcnt = done_cnt;
    load_key(KEY_A3);
    repeat (5) @(posedge clk);
    #1 check("ab_at5", {124'd0, rk_idx}, 128'd5);
    key      = '0;
    key_load = 1'b1;
    @(posedge clk); #1;
    key_load = 1'b0;
    sb_on    = 1'b0;
    check("ab_q_empty", 128'(exp_q.size()), 128'd0);
    check("ab_idx0", {124'd0, rk_idx}, 128'd0);
    check("ab_rk0", rk_data, 128'd0);
    check("ab_valid", {126'd0, rk_valid, busy}, 128'd3);
    @(posedge clk); #1 check("zk_rk1", rk_data, 128'd0);
    @(posedge clk); #1 check("zk_rk2", rk_data, 128'h62636363626363636263636362636363);
    @(posedge clk); #1 check("zk_rk3", rk_data, 128'haafbfbfbaafbfbfbaafbfbfbaafbfbfb);
    repeat (12) @(posedge clk);
    #1 check("zk_done", {126'd0, done, busy}, 128'd2);
    @(posedge clk); #1;
    check("ab_one_done", 128'(done_cnt - dcnt), 128'd1);

    // Asynchronous reset at rk_idx=7.
    dcnt = done_cnt;
    load_key(KEY_A3);
    repeat (7) @(posedge clk);
    #1 check("ar_at7", {124'd0, rk_idx}, 128'd7);
    #2 rst = 1'b0;
    #1;
    check("ar_ctrl", {125'd0, rk_valid, busy, done}, 128'd0);
    check("ar_data", rk_data, 128'd0);
    repeat (3) @(posedge clk);
    #1 check("ar_hold", {125'd0, rk_valid, busy, done}, 128'd0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("ar_no_done", 128'(done_cnt - dcnt), 128'd0);
    check("ar_idle", {126'd0, rk_valid, busy}, 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aes256_key_expand.md
Name: aes256_key_expand

Overview:
Iterative AES-256 key-schedule stage, directly upstream of the AES-256 round datapath.
- Takes the 256-bit cipher key and emits the 15 round keys (rk0..rk14, 128 bits each) in order over a valid/ready stream.
- Produces one round key per accepted transfer, using four internal S-box lookups per cycle.
- The round datapath consumes rk_data as its AddRoundKey operand.

Parameters:
ZERO_ON_IDLE, 1, when 1 rk_data is forced to 0 whenever rk_valid=0; when 0 rk_data shows the window register at all times

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
key  in  256  cipher key; key[255:224]=w0 … key[31:0]=w7
key_load  in  1  start pulse; key sampled on this cycle
rk_ready  in  1  downstream accepts rk_data
rk_valid  out  1  rk_data holds a valid round key
rk_data  out  128  round key; word 0 in [127:96]
rk_idx  out  4  index of rk_data, 0..14
rk_last  out  1  high with rk_valid when rk_idx=14
busy  out  1  high from key_load until final transfer
done  out  1  one-cycle pulse after transfer of rk14

Behaviour:
- Reset (rst=0, async): all outputs are 0, state=IDLE, window=0, idx=0.
- Window register: 8 words W0..W7 (256 bits). rk_data = {W0,W1,W2,W3}.
- States are IDLE and RUN.
- IDLE:
  - rk_valid=0.
  - On key_load: window<=key, idx<=0, busy<=1, next state RUN.
  - rk_valid=1 with rk_idx=0 on the next cycle (1-cycle latency).
- RUN:
  - rk_valid=1.
  - rk_data/rk_idx are held stable while rk_ready=0.
- Transfer = rk_valid & rk_ready. On a transfer in RUN with idx<14:
  - idx<=idx+1.
  - window<={W4..W7, N0..N3}.
  - N0 = W0 ^ T. N1 = W1 ^ N0. N2 = W2 ^ N1. N3 = W3 ^ N2.
  - If idx even: T = SubWord(RotWord(W7)) ^ {RCON[(idx+2)/2],24'h0}, with RCON[1..7] = 01,02,04,08,10,20,40.
  - If idx odd: T = SubWord(W7).
  - RotWord: {a,b,c,d}->{b,c,d,a}. SubWord: FIPS-197 S-box on each byte.
- On a transfer in RUN with idx=14: next state IDLE, rk_valid<=0, busy<=0, done<=1 for one cycle.
- key_load during RUN: aborts the current schedule and restarts from the new key (same as the IDLE load). No done pulse for the aborted schedule.
- key_load coincident with a transfer: key_load wins and the transfer is discarded. This includes the idx=14 case, which then gives no done pulse.
- rk_ready while in IDLE is ignored.
- rk_last = rk_valid & (idx==14).
- Generation is computed combinationally from the window (four S-boxes in the N0..N3 path) and registered at the transfer. No extra latency between successive round keys: with rk_ready held high, 15 keys are emitted in 15 consecutive cycles.
- Reset asserted mid-schedule: returns to IDLE immediately with all outputs 0.

Optional Feature:
Macro AES256_KE_STORE_EN.
- Defined:
  - Adds a 15x128 register bank, written with rk_data on every transfer at rk_idx.
  - Adds ports rd_idx (in, 4), rd_data (out, 128) and store_valid (out, 1).
  - rd_data = bank[rd_idx], combinational. rd_idx>14 returns 0.
  - store_valid is set by done, cleared by key_load or reset.
  - The bank is cleared on reset only.
- Undefined: no bank and no extra ports; behaviour is otherwise identical.

Test Plan:
- Reset then idle: rst low 3 cycles, release, no key_load -> all outputs 0, rk_valid=0 for 10 cycles.
- FIPS-197 A.3 key with key_load and rk_ready=1:
  - key = 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4.
  - Expect rk0=603deb1015ca71be2b73aef0857d7781, rk1=1f352c073b6108d72d9810a30914dff4, rk2=9ba354118e6925afa51a8b5f2067fcde, rk3=a8b09c1a93d194cdbe49846eb75d5b9a.
  - Expect rk14=fe4890d1e6188d0b046df344706c631e with rk_last=1.
  - Then done pulses 1 cycle and busy falls.
- Backpressure: same key, rk_ready toggled pseudo-randomly -> same 15 keys in order; rk_data/rk_idx stable while rk_ready=0; no key dropped or duplicated.
- Abort/restart: key_load with key of all 0 at rk_idx=5 -> next cycle rk_idx=0 and rk_data=0; the all-zero schedule completes with rk2=62636363626363636263636362636363.
- Async reset mid-run: rst low asynchronously at rk_idx=7 -> rk_valid, busy and rk_data go to 0 without a clock edge; no done pulse.
- AES256_KE_STORE_EN defined: after the A.3 run, rd_idx=3 -> a8b09c1a93d194cdbe49846eb75d5b9a; rd_idx=15 -> 0; store_valid=1 until the next key_load.
